// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address and registers the word into IF/ID (one-edge latency).
// stall_f holds the PC, stall_d holds IF/ID, flush_d loads a NOP; misaligned-redirect trap built only with FETCH_MISALIGN_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_err
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH * 4);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc_id_q, pc_id_n;
  logic [31:0] pc4_id_q, pc4_id_n;
  logic        vld_q, vld_n;
  logic        err_q, err_n;

  logic        misalign;
  logic        in_range;
  logic [31:0] pc_f_plus4;

  assign pc_f_plus4 = pc_f_q + 32'd4;
  assign in_range   = (pc_f_q < IMEM_LIMIT);

`ifdef FETCH_MISALIGN_EN
  assign misalign = pc_src_e && (pc_target_e[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_f_d   = pc_f_q;
    instr_n  = instr_q;
    pc_id_n  = pc_id_q;
    pc4_id_n = pc4_id_q;
    vld_n    = vld_q;
    err_n    = err_q;

    case (state_q)
      BOOT: begin
        state_d  = RUN;
        instr_n  = NOP_INSTR;
        pc_id_n  = 32'd0;
        pc4_id_n = 32'd0;
        vld_n    = 1'b0;
      end

      RUN: begin
        if (misalign) begin
          // Bad target: freeze PC, latch the error and park in TRAP until reset.
          err_n   = 1'b1;
          state_d = TRAP;
          if (!(stall_d && !flush_d)) begin
            instr_n  = NOP_INSTR;
            pc_id_n  = 32'd0;
            pc4_id_n = 32'd0;
            vld_n    = 1'b0;
          end
        end else begin
          if (pc_src_e) begin
            pc_f_d = pc_target_e & ~32'h0000_0003;
          end else if (!stall_f) begin
            pc_f_d = pc_f_plus4;
          end

          if (flush_d) begin
            instr_n  = NOP_INSTR;
            pc_id_n  = 32'd0;
            pc4_id_n = 32'd0;
            vld_n    = 1'b0;
          end else if (!stall_d) begin
            pc_id_n  = pc_f_q;
            pc4_id_n = pc_f_plus4;
            // Past the end of instruction memory: keep the PC for debug but hide the word.
            if (in_range) begin
              instr_n = imem_rd;
              vld_n   = 1'b1;
            end else begin
              instr_n = NOP_INSTR;
              vld_n   = 1'b0;
            end
          end
        end
      end

      TRAP: begin
        instr_n  = NOP_INSTR;
        pc_id_n  = 32'd0;
        pc4_id_n = 32'd0;
        vld_n    = 1'b0;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_f_q   <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_id_q  <= 32'd0;
      pc4_id_q <= 32'd0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      instr_q  <= instr_n;
      pc_id_q  <= pc_id_n;
      pc4_id_q <= pc4_id_n;
      vld_q    <= vld_n;
      err_q    <= err_n;
    end
  end

  assign imem_addr  = pc_f_q;
  assign instr_d    = instr_q;
  assign pc_d       = pc_id_q;
  assign pc_plus4_d = pc4_id_q;
  assign valid_d    = vld_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expected values are hand-derived for IMEM_DEPTH=64, RESET_PC=0.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013),
    .IMEM_DEPTH(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d),
    .fetch_err  (fetch_err)
  );

  // Memory model: word 0 is the addi from the test plan, every other address returns a tagged word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h0280_0813;
    return {16'hA5A5, a[15:0]};
  endfunction

  assign imem_rd = word_at(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("assertion %s", tag);
    end
  endtask

  initial begin
    reset = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'd0;
    #1 reset = 1'b1;
    #2;
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_instr", instr_d, 32'h13);
    check("rst_pc",    pc_d, 32'h0);
    check("rst_pc4",   pc_plus4_d, 32'h0);
    check("rst_vld",   valid_d, 1'b0);
    check("rst_err",   fetch_err, 1'b0);

    #5 reset = 1'b0;
    tick();  // BOOT edge
    check("boot_vld",   valid_d, 1'b0);
    check("boot_addr",  imem_addr, 32'h0);
    check("boot_instr", instr_d, 32'h13);
    tick();
    check("run0_instr", instr_d, 32'h0280_0813);
    check("run0_pc",    pc_d, 32'h0);
    check("run0_pc4",   pc_plus4_d, 32'h4);
    check("run0_vld",   valid_d, 1'b1);
    check("run0_addr",  imem_addr, 32'h4);
    tick();
    check("run1_instr", instr_d, 32'hA5A5_0004);
    check("run1_addr",  imem_addr, 32'h8);
    tick();
    tick();
    check("pre_stall_addr", imem_addr, 32'h10);
    check("pre_stall_pc",   pc_d, 32'hC);

    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  imem_addr, 32'h10);
      check("stall_pc",    pc_d, 32'hC);
      check("stall_instr", instr_d, 32'hA5A5_000C);
    end
    stall_f = 1'b0; stall_d = 1'b0;
    tick();
    check("unstall_pc",    pc_d, 32'h10);
    check("unstall_instr", instr_d, 32'hA5A5_0010);
    check("unstall_addr",  imem_addr, 32'h14);

    // Redirect beats stall_f; flush_d squashes IF/ID.
    pc_src_e = 1'b1; pc_target_e = 32'h64; flush_d = 1'b1; stall_f = 1'b1;
    tick();
    check("redir_addr",  imem_addr, 32'h64);
    check("redir_instr", instr_d, 32'h13);
    check("redir_vld",   valid_d, 1'b0);
    check("redir_pc",    pc_d, 32'h0);
    pc_src_e = 1'b0; flush_d = 1'b0; stall_f = 1'b0;
    tick();
    check("tgt_pc",    pc_d, 32'h64);
    check("tgt_pc4",   pc_plus4_d, 32'h68);
    check("tgt_instr", instr_d, 32'hA5A5_0064);
    check("tgt_vld",   valid_d, 1'b1);

    // Walk across the end of instruction memory.
    pc_src_e = 1'b1; pc_target_e = 32'hF8; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0;
    tick();
    tick();
    check("last_pc",  pc_d, 32'hFC);
    check("last_vld", valid_d, 1'b1);
    check("oor_addr_pre", imem_addr, 32'h100);
    tick();
    check("oor_instr", instr_d, 32'h13);
    check("oor_vld",   valid_d, 1'b0);
    check("oor_pc",    pc_d, 32'h100);
    check("oor_addr",  imem_addr, 32'h104);
    tick();
    check("oor2_pc",  pc_d, 32'h104);
    check("oor2_vld", valid_d, 1'b0);

    // Misaligned redirect to 0x66 issued while pc_f = 0x108.
    pc_src_e = 1'b1; pc_target_e = 32'h66;
    tick();
    pc_src_e = 1'b0;
`ifdef FETCH_MISALIGN_EN
    check("mis_err",  fetch_err, 1'b1);
    check("mis_addr", imem_addr, 32'h108);
    check("mis_vld",  valid_d, 1'b0);
    tick();
    tick();
    check("trap_err",  fetch_err, 1'b1);
    check("trap_addr", imem_addr, 32'h108);
    check("trap_vld",  valid_d, 1'b0);
    check("trap_instr", instr_d, 32'h13);
`else
    check("mis_err",  fetch_err, 1'b0);
    check("mis_addr", imem_addr, 32'h64);
    tick();
    check("mis_pc",  pc_d, 32'h64);
    check("mis_vld", valid_d, 1'b1);
    check("mis_err2", fetch_err, 1'b0);
`endif

    // Reset from any state, then park at 0x40 with stall_f held.
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    tick();  // BOOT
    pc_src_e = 1'b1; pc_target_e = 32'h40; flush_d = 1'b1;
    tick();
    pc_src_e = 1'b0; flush_d = 1'b0; stall_f = 1'b1;
    check("park_addr", imem_addr, 32'h40);
    tick();
    check("park_hold", imem_addr, 32'h40);
    check("park_vld",  valid_d, 1'b1);

    #2 reset = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h80;
    #1;
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_instr", instr_d, 32'h13);
    check("arst_pc",    pc_d, 32'h0);
    check("arst_pc4",   pc_plus4_d, 32'h0);
    check("arst_vld",   valid_d, 1'b0);
    check("arst_err",   fetch_err, 1'b0);
    tick();
    check("arst_hold_addr", imem_addr, 32'h0);
    #2 reset = 1'b0; pc_src_e = 1'b0; stall_f = 1'b0;
    tick();  // BOOT
    check("reboot_vld",  valid_d, 1'b0);
    check("reboot_addr", imem_addr, 32'h0);
    tick();
    check("refetch_instr", instr_d, 32'h0280_0813);
    check("refetch_pc",    pc_d, 32'h0);
    check("refetch_vld",   valid_d, 1'b1);
    check("refetch_addr",  imem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
